spi_master_engine: RTL and testbench
====================================

# spi_master_engine

SPI master (mode 0, MSB first) that executes one transfer per request from the ADC-side controller over the spi_start / spi_tx / spi_bits / spi_rx / spi_done request interface. It drives the physical cs_n / sclk / mosi pins toward the MCP3910 and captures miso. It sits between the MCP3910 controller FSM and the board pins, in the same single clock domain. It buffers one back-to-back request so the controller can restart immediately after spi_done without checking a busy flag.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; also the CS lead, CS lag and CS-high guard time; legal range 1..255.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- spi_start  in  1  single-cycle transfer request.
- spi_tx  in  32  transmit word, left-justified; spi_tx[31] is sent first.
- spi_bits  in  6  transfer length N; 1..32 legal; 33..63 clamp to 32; 0 special, see Operation.
- spi_rx  out  32  received bits, right-justified in spi_rx[N-1:0], upper bits 0; held until the next completion.
- spi_done  out  1  one-cycle pulse; spi_rx is valid in the same cycle.
- spi_busy  out  1  high from request acceptance until the guard time expires.
- cs_n  out  1  chip select, active low.
- sclk  out  1  serial clock, idle low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

## Operation
- States: IDLE, SETUP, XFER, HOLD, DONE, GUARD.
- IDLE, spi_start=1:
  - Latch spi_tx and clamped N into a shift register and a bit counter.
  - Go to SETUP.
  - With N=0: skip all pins, go straight to DONE with spi_rx=0.
- SETUP, CLK_DIV cycles:
  - cs_n=0, mosi=tx[31], sclk=0.
- XFER, N bits, each 2*CLK_DIV cycles:
  - High phase (CLK_DIV cycles), then low phase (CLK_DIV cycles).
  - miso is sampled on the clk edge that drives sclk 0→1 and shifted into the rx shift register LSB.
  - The clk edge that drives sclk 1→0 shifts the tx register left and presents the next bit on mosi.
  - The counter decrements per bit; after the Nth low phase, go to HOLD.
- HOLD, CLK_DIV cycles:
  - cs_n=0, sclk=0, mosi holds the last value.
- DONE, 1 cycle:
  - cs_n=1, mosi=0, spi_done=1.
  - spi_rx = rx shift register, zero-extended above N.
- GUARD, CLK_DIV cycles:
  - cs_n=1, spi_busy=1.
  - On exit: if a pending request exists, start SETUP with the pending data; otherwise go to IDLE.
- Request handling:
  - spi_start in DONE or GUARD is latched as pending (spi_tx and spi_bits captured that cycle). A second start in the same window overwrites the pending one.
  - spi_start during SETUP, XFER or HOLD is ignored.
- spi_busy is 0 only in IDLE with no pending request.

## Timing
- Reset values: cs_n=1, sclk=0, mosi=0, spi_done=0, spi_busy=0, spi_rx=0; state=IDLE, pending cleared.
- rst mid-transfer: outputs take their reset values on the next cycle; no spi_done; spi_rx is cleared.
- Start sampled at cycle 0 (IDLE):
  - cs_n falls and spi_busy rises at cycle 1.
  - First sclk rise at cycle 1+CLK_DIV.
  - spi_done at cycle 1 + CLK_DIV*(2N+2).
  - spi_busy falls at cycle 2 + CLK_DIV*(2N+3) with no pending request.
- Default CLK_DIV=4, N=32: spi_done at cycle 265.
- Pending request: cs_n falls again on the first cycle after GUARD, giving CS high for exactly CLK_DIV+1 cycles.
- N=0: spi_done at cycle 1, pins untouched, then GUARD as normal.
- spi_rx and spi_done are registered outputs; no combinational path from any input to any output.

## Test plan
- Reset then idle:
  - Stimulus: rst high 3 cycles, then low.
  - Response: cs_n=1, sclk=0, mosi=0, spi_busy=0, spi_rx=0; no pin toggles for 100 cycles.
- Single 32-bit read (CLK_DIV=4):
  - Stimulus: spi_tx=0x01000000, spi_bits=32, slave model returns 0x00ABCDEF.
  - Response:
    - mosi shows 0x01 followed by 24 zeros.
    - Exactly 32 sclk rises.
    - spi_done at cycle 265 with spi_rx=0x00ABCDEF.
- Short transfer with clamping:
  - Stimulus: spi_bits=8, spi_tx=0xA5xxxxxx, miso byte 0x3C.
  - Response: 8 sclk pulses, spi_rx=0x0000003C.
  - Stimulus: spi_bits=40.
  - Response: 32 pulses.
- Back-to-back:
  - Stimulus: second spi_start one cycle after spi_done.
  - Response: second transfer runs with its own tx data; CS high for exactly CLK_DIV+1 cycles; two spi_done pulses.
- Ignored and zero-length requests:
  - Stimulus: spi_start mid-XFER.
  - Response: no effect; one spi_done only.
  - Stimulus: spi_bits=0.
  - Response: spi_done at cycle 1, spi_rx=0, cs_n never low.
- Reset mid-transfer:
  - Stimulus: rst asserted after 10 sclk rises.
  - Response: next cycle cs_n=1, sclk=0, spi_busy=0; no spi_done; a subsequent transfer completes correctly.

Source files
------------

// File: rtl/spi_master_engine.sv
// SPI mode-0 master, MSB first, 1..32-bit transfers, with one buffered back-to-back request.
// All outputs are registered; CLK_DIV sets the SCLK half-period and the CS lead/lag/guard times.
module spi_master_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_start,
  input  logic [31:0] spi_tx,
  input  logic [5:0]  spi_bits,
  output logic [31:0] spi_rx,
  output logic        spi_done,
  output logic        spi_busy,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE, GUARD} state_t;

  state_t      state_reg;
  logic [7:0]  timer_reg;
  logic [5:0]  bit_cnt_reg;
  logic [31:0] tx_sr_reg;
  logic [31:0] rx_sr_reg;
  logic        pend_valid_reg;
  logic [31:0] pend_tx_reg;
  logic [5:0]  pend_bits_reg;

  logic        timer_last;
  logic        launch;
  logic [31:0] ld_tx;
  logic [5:0]  ld_n;
  logic [5:0]  start_n;

  always_comb begin
    start_n    = (spi_bits > 6'd32) ? 6'd32 : spi_bits;
    timer_last = (timer_reg == 8'(CLK_DIV - 1));
    // A start arriving in the last GUARD cycle is newer than any pending one, so it wins.
    launch     = ((state_reg == IDLE) && spi_start) ||
                 ((state_reg == GUARD) && timer_last && (pend_valid_reg || spi_start));
    ld_tx      = ((state_reg == GUARD) && !spi_start) ? pend_tx_reg : spi_tx;
    ld_n       = ((state_reg == GUARD) && !spi_start) ? pend_bits_reg : start_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      bit_cnt_reg    <= '0;
      tx_sr_reg      <= '0;
      rx_sr_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_tx_reg    <= '0;
      pend_bits_reg  <= '0;
      spi_rx         <= '0;
      spi_done       <= 1'b0;
      spi_busy       <= 1'b0;
      cs_n           <= 1'b1;
      sclk           <= 1'b0;
      mosi           <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      if (((state_reg == DONE) || (state_reg == GUARD)) && spi_start) begin
        pend_valid_reg <= 1'b1;
        pend_tx_reg    <= spi_tx;
        pend_bits_reg  <= start_n;
      end

      if (launch) begin
        pend_valid_reg <= 1'b0;
        spi_busy       <= 1'b1;
        timer_reg      <= '0;
        tx_sr_reg      <= ld_tx;
        rx_sr_reg      <= '0;
        bit_cnt_reg    <= ld_n;
        sclk           <= 1'b0;
        if (ld_n == 6'd0) begin
          // Zero-length request completes immediately without touching the pins.
          state_reg <= DONE;
          spi_done  <= 1'b1;
          spi_rx    <= '0;
          cs_n      <= 1'b1;
          mosi      <= 1'b0;
        end else begin
          state_reg <= SETUP;
          cs_n      <= 1'b0;
          mosi      <= ld_tx[31];
        end
      end else begin
        case (state_reg)
          SETUP: begin
            if (timer_last) begin
              timer_reg <= '0;
              state_reg <= XFER;
              sclk      <= 1'b1;
              rx_sr_reg <= {rx_sr_reg[30:0], miso};
            end else begin
              timer_reg <= timer_reg + 8'd1;
            end
          end
          XFER: begin
            if (timer_last) begin
              timer_reg <= '0;
              if (sclk) begin
                sclk        <= 1'b0;
                tx_sr_reg   <= {tx_sr_reg[30:0], 1'b0};
                mosi        <= tx_sr_reg[30];
                bit_cnt_reg <= bit_cnt_reg - 6'd1;
              end else if (bit_cnt_reg == 6'd0) begin
                state_reg <= HOLD;
              end else begin
                sclk      <= 1'b1;
                rx_sr_reg <= {rx_sr_reg[30:0], miso};
              end
            end else begin
              timer_reg <= timer_reg + 8'd1;
            end
          end
          HOLD: begin
            if (timer_last) begin
              timer_reg <= '0;
              state_reg <= DONE;
              cs_n      <= 1'b1;
              mosi      <= 1'b0;
              spi_done  <= 1'b1;
              spi_rx    <= rx_sr_reg;
            end else begin
              timer_reg <= timer_reg + 8'd1;
            end
          end
          DONE: begin
            timer_reg <= '0;
            state_reg <= GUARD;
          end
          GUARD: begin
            if (timer_last) begin
              timer_reg <= '0;
              state_reg <= IDLE;
              spi_busy  <= 1'b0;
            end else begin
              timer_reg <= timer_reg + 8'd1;
            end
          end
          default: begin
            timer_reg <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Randomized bench for spi_master_engine: a slave model feeds miso, a reference model
// predicts rx data, mosi stream, sclk count and cycle timing from the transfer length.
module tb_spi_master_engine;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_start = 1'b0;
  logic [31:0] spi_tx = '0;
  logic [5:0]  spi_bits = '0;
  logic [31:0] spi_rx;
  logic        spi_done;
  logic        spi_busy;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso;

  int n_cmp = 0;
  int n_err = 0;

  int          rises_total = 0;
  logic        mosi_log [0:8191];
  int          base_rise = 0;
  logic [31:0] slave_word = '0;
  int          slave_n = 0;
  int          idx;

  spi_master_engine #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .spi_start(spi_start), .spi_tx(spi_tx), .spi_bits(spi_bits),
    .spi_rx(spi_rx), .spi_done(spi_done), .spi_busy(spi_busy),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Slave log: record mosi at every sclk rise, advance the miso bit pointer.
  always @(posedge sclk) begin
    mosi_log[rises_total % 8192] <= mosi;
    rises_total <= rises_total + 1;
  end

  // Slave presents its word MSB first over the transfer's N bits.
  always_comb begin
    idx  = rises_total - base_rise;
    miso = 1'b0;
    if (idx >= 0 && idx < slave_n) miso = slave_word[slave_n - 1 - idx];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int clamp_n(input logic [5:0] b);
    return (b > 6'd32) ? 32 : int'(b);
  endfunction

  function automatic logic [31:0] exp_rx(input logic [31:0] sw, input int n);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    return sw & mask[31:0];
  endfunction

  function automatic logic [31:0] exp_mosi(input logic [31:0] tx, input int n);
    return (n == 0) ? 32'd0 : (tx >> (32 - n));
  endfunction

  function automatic logic [31:0] mosi_word(input int b, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = {w[30:0], mosi_log[(b + i) % 8192]};
    return w;
  endfunction

  task automatic pulse_start(input logic [31:0] tx, input logic [5:0] bits);
    @(negedge clk);
    spi_start = 1'b1;
    spi_tx    = tx;
    spi_bits  = bits;
    @(negedge clk);
    spi_start = 1'b0;
  endtask

  // One transfer; inj_cyc > 0 fires an extra (to-be-ignored) start at that cycle.
  task automatic run_xfer(input logic [31:0] tx, input logic [5:0] bits,
                          input logic [31:0] sw, input int inj_cyc);
    int n, cyc, done_cnt, done_cyc, cs_low, b;
    logic [31:0] rx_got;
    n = clamp_n(bits);
    slave_word = sw;
    slave_n    = n;
    base_rise  = rises_total;
    b          = rises_total;
    done_cnt = 0; done_cyc = -1; cs_low = 0; rx_got = '0;
    pulse_start(tx, bits);
    cyc = 1;
    chk("cs_n_c1", {31'd0, cs_n}, (n == 0) ? 32'd1 : 32'd0);
    chk("busy_c1", {31'd0, spi_busy}, 32'd1);
    while (spi_busy && cyc < 3000) begin
      if (spi_done) begin
        done_cnt++;
        done_cyc = cyc;
        rx_got   = spi_rx;
      end
      if (!cs_n) cs_low++;
      spi_start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        spi_tx   = ~tx;
        spi_bits = 6'd32;
      end
      @(negedge clk);
      cyc++;
    end
    spi_start = 1'b0;
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("done_cyc", 32'(done_cyc), (n == 0) ? 32'd1 : 32'(1 + CD * (2 * n + 2)));
    chk("rx", rx_got, exp_rx(sw, n));
    chk("sclk_rises", 32'(rises_total - b), 32'(n));
    chk("mosi_bits", mosi_word(b, n), exp_mosi(tx, n));
    chk("cs_low_cyc", 32'(cs_low), (n == 0) ? 32'd0 : 32'(CD * (2 * n + 2)));
    chk("busy_fall", 32'(cyc), (n == 0) ? 32'(2 + CD) : 32'(2 + CD * (2 * n + 3)));
    repeat (3) @(negedge clk);
    chk("rx_hold", spi_rx, exp_rx(sw, n));
    $display("xfer tx=%08h bits=%0d miso=%08h -> rx=%08h done@%0d busy_fall@%0d",
             tx, bits, sw, rx_got, done_cyc, cyc);
  endtask

  // Second request issued one cycle after the first spi_done.
  task automatic run_b2b(input logic [31:0] tx1, input logic [5:0] b1, input logic [31:0] sw1,
                         input logic [31:0] tx2, input logic [5:0] b2, input logic [31:0] sw2);
    int n1, n2, cyc, done_cnt, d1, d2, gap, base1, base2;
    logic gap_done;
    logic [31:0] rx1, rx2;
    n1 = clamp_n(b1);
    n2 = clamp_n(b2);
    slave_word = sw1; slave_n = n1; base_rise = rises_total; base1 = rises_total; base2 = 0;
    done_cnt = 0; d1 = -1; d2 = -1; gap = 0; gap_done = 1'b0; rx1 = '0; rx2 = '0;
    pulse_start(tx1, b1);
    cyc = 1;
    while (spi_busy && cyc < 6000) begin
      if (spi_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          d1 = cyc; rx1 = spi_rx;
          chk("b2b_mosi1", mosi_word(base1, n1), exp_mosi(tx1, n1));
        end else begin
          d2 = cyc; rx2 = spi_rx;
        end
      end
      if (d1 > 0 && !gap_done) begin
        if (cs_n) gap++;
        else gap_done = 1'b1;
      end
      spi_start = (d1 > 0 && cyc == d1 + 1);
      if (d1 > 0 && cyc == d1 + 1) begin
        spi_tx = tx2; spi_bits = b2;
        slave_word = sw2; slave_n = n2; base_rise = rises_total; base2 = rises_total;
      end
      @(negedge clk);
      cyc++;
    end
    spi_start = 1'b0;
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_rx1", rx1, exp_rx(sw1, n1));
    chk("b2b_rx2", rx2, exp_rx(sw2, n2));
    chk("b2b_cs_gap", 32'(gap), 32'(CD + 1));
    chk("b2b_d2", 32'(d2), 32'(d1 + CD + 1 + CD * (2 * n2 + 2)));
    chk("b2b_mosi2", mosi_word(base2, n2), exp_mosi(tx2, n2));
    chk("b2b_rises2", 32'(rises_total - base2), 32'(n2));
    $display("b2b tx1=%08h tx2=%08h -> rx1=%08h rx2=%08h gap=%0d", tx1, tx2, rx1, rx2, gap);
  endtask

  initial begin
    int toggles, k, dn;
    logic pc, ps, pm;
    logic [5:0] rb;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, spi_busy}, 32'd0);
    chk("rst_rx", spi_rx, 32'd0);
    toggles = 0; pc = cs_n; ps = sclk; pm = mosi;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cs_n !== pc || sclk !== ps || mosi !== pm || spi_busy !== 1'b0) toggles++;
      pc = cs_n; ps = sclk; pm = mosi;
    end
    chk("idle_toggles", 32'(toggles), 32'd0);
    $display("reset/idle checked, toggles=%0d", toggles);

    // Directed transfers
    run_xfer(32'h0100_0000, 6'd32, 32'h00AB_CDEF, 0);
    run_xfer(32'hA512_3456, 6'd8, 32'h0000_003C, 0);
    run_xfer($urandom, 6'd40, $urandom, 0);
    run_xfer($urandom, 6'd0, $urandom, 0);
    run_xfer($urandom, 6'd16, $urandom, 1 + CD + 5);
    run_b2b($urandom, 6'd12, $urandom, $urandom, 6'd20, $urandom);

    // Reset mid-transfer
    slave_word = $urandom; slave_n = 32; base_rise = rises_total;
    pulse_start($urandom, 6'd32);
    k = 0; dn = 0;
    while ((rises_total - base_rise) < 10 && k < 2000) begin
      if (spi_done) dn++;
      @(negedge clk);
      k++;
    end
    chk("rst_mid_wait", {31'd0, k < 2000}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rstm_sclk", {31'd0, sclk}, 32'd0);
    chk("rstm_busy", {31'd0, spi_busy}, 32'd0);
    chk("rstm_rx", spi_rx, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (spi_done) dn++;
      @(negedge clk);
    end
    chk("rstm_no_done", 32'(dn), 32'd0);
    $display("reset mid-transfer after %0d cycles", k);
    run_xfer($urandom, 6'd24, $urandom, 0);

    // Randomized transfers
    for (int t = 0; t < 10; t++) begin
      rb = 6'($urandom_range(0, 63));
      run_xfer($urandom, rb, $urandom,
               (rb != 6'd0 && ($urandom_range(0, 1) == 1)) ? 1 + CD + 3 : 0);
    end
    run_b2b($urandom, 6'($urandom_range(1, 63)), $urandom,
            $urandom, 6'($urandom_range(1, 63)), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
